image_stream_reader: RTL

- Reader side of the 32x32 canvas bitmap that the VGA/mouse drawing block writes.
- On a start request it snapshots the 1024-bit image so the user can keep drawing without tearing the frame in flight.
- Streams the snapshot row-major, one pixel per beat, over a valid/ready interface to the DNN input buffer.
- While streaming it accumulates a pixel count and bounding box for the preprocessing/centering logic.

---
 rtl/image_stream_reader_if.sv | 13 +
 rtl/image_stream_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/image_stream_reader_if.sv
// Pixel stream from the canvas snapshot reader to the DNN input buffer.
// The master drives beats and the slave returns ready.
interface image_stream_reader_if #(
  parameter int unsigned DATA_W = 16
);
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic              oLast;
  logic              iReady;

  modport master (output oValid, oData, oLast, input iReady);
  modport slave  (input oValid, oData, oLast, output iReady);
endinterface

// File: rtl/image_stream_reader.sv
// Snapshots the 32x32 canvas on start and streams it row-major, one pixel per beat.
// While streaming, it accumulates the set-pixel count and bounding box for centering.
module image_stream_reader #(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] PIX_ONE  = 16'h0100,
  parameter logic [DATA_W-1:0] PIX_ZERO = 16'h0000
) (
  input  logic                  clkVga,
  input  logic                  iRstN,
  input  logic [1023:0]         iImage,
  input  logic                  iStart,
  output logic                  oBusy,
  image_stream_reader_if.master stream,
  output logic                  oDone,
  output logic [10:0]           oPixCount,
  output logic                  oBBoxValid,
  output logic [4:0]            oXMin,
  output logic [4:0]            oXMax,
  output logic [4:0]            oYMin,
  output logic [4:0]            oYMax
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state_q;
  logic [1023:0]       snap_q;
  logic [9:0]          beat_q;
  logic                valid_q, last_q, busy_q, done_q, bbox_q;
  logic [DATA_W-1:0]   data_q;
  logic [10:0]         pixcnt_q;
  logic [4:0]          xmin_q, xmax_q, ymin_q, ymax_q;

  logic [9:0]          nxt_beat_d;
  logic                cur_pix_d, nxt_pix_d;
  logic [4:0]          cur_x_d, cur_y_d;

  // Beat k is (x=k[4:0], y=k[9:5]); the bitmap is indexed {x,y}, so the halves swap.
  always_comb begin
    nxt_beat_d = beat_q + 10'd1;
    cur_x_d    = beat_q[4:0];
    cur_y_d    = beat_q[9:5];
    cur_pix_d  = snap_q[{beat_q[4:0], beat_q[9:5]}];
    nxt_pix_d  = snap_q[{nxt_beat_d[4:0], nxt_beat_d[9:5]}];
  end

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pixcnt_q <= '0;
      bbox_q   <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q  <= STREAM;
            snap_q   <= iImage;
            beat_q   <= '0;
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            // Beat 0 comes straight from the input since the snapshot is loading now.
            data_q   <= iImage[0] ? PIX_ONE : PIX_ZERO;
            busy_q   <= 1'b1;
            pixcnt_q <= '0;
            bbox_q   <= 1'b0;
            xmin_q   <= '1;
            ymin_q   <= '1;
            xmax_q   <= '0;
            ymax_q   <= '0;
          end
        end
        STREAM: begin
          if (valid_q && stream.iReady) begin
            if (cur_pix_d) begin
              pixcnt_q <= pixcnt_q + 11'd1;
              bbox_q   <= 1'b1;
              if (cur_x_d < xmin_q) xmin_q <= cur_x_d;
              if (cur_x_d > xmax_q) xmax_q <= cur_x_d;
              if (cur_y_d < ymin_q) ymin_q <= cur_y_d;
              if (cur_y_d > ymax_q) ymax_q <= cur_y_d;
            end
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= PIX_ZERO;
              done_q  <= 1'b1;
            end else begin
              beat_q  <= nxt_beat_d;
              data_q  <= nxt_pix_d ? PIX_ONE : PIX_ZERO;
              last_q  <= (nxt_beat_d == 10'h3FF);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stream.oValid = valid_q;
  assign stream.oData  = data_q;
  assign stream.oLast  = last_q;
  assign oBusy         = busy_q;
  assign oDone         = done_q;
  assign oPixCount     = pixcnt_q;
  assign oBBoxValid    = bbox_q;
  assign oXMin         = xmin_q;
  assign oXMax         = xmax_q;
  assign oYMin         = ymin_q;
  assign oYMax         = ymax_q;

endmodule
